id_ex_skid: RTL and testbench

ID_EX_SKID -- requirements
Module: id_ex_skid

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/id_ex_skid.sv | 139 +++++++++++++
 tb/tb_id_ex_skid.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared ID/EX pipeline types: the decode-to-execute payload and the
// occupancy encoding used by the ID/EX skid buffer.
package cpu_pkg;

  // Operand width carried by the ID/EX payload.
  localparam int XLEN = 32;

  // Occupancy of the ID/EX stage: nothing held, main only, main plus skid.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Decoded instruction as handed from decode to execute.
  typedef struct packed {
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic [XLEN-1:0] s_data;
  } id_ex_t;

endpackage

// File: rtl/id_ex_skid.sv
// ID/EX pipeline register with a one-entry skid buffer.
// in_ready comes straight from a flop, so there is no combinational path
// from out_ready back to decode. Payload is forced to zero whenever the
// stage holds nothing. DATA_W is expected to equal cpu_pkg::XLEN.
// Optional: define ID_EX_PERF_EN to add saturating stall/bubble counters
// (stall_cnt, bubble_cnt ports).
module id_ex_skid
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_op,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [DATA_W-1:0] in_operand1,
  input  logic [DATA_W-1:0] in_operand2,
  input  logic [DATA_W-1:0] in_s_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        out_op,
  output logic [2:0]        out_funct3,
  output logic [6:0]        out_funct7,
  output logic [4:0]        out_rd,
  output logic [DATA_W-1:0] out_operand1,
  output logic [DATA_W-1:0] out_operand2,
  output logic [DATA_W-1:0] out_s_data
`ifdef ID_EX_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  occ_e   state_q, state_d;
  id_ex_t main_q, main_d;
  id_ex_t skid_q, skid_d;
  id_ex_t in_pl;
  logic   in_ready_q;
  logic   accept;

  assign in_pl  = {in_op, in_funct3, in_funct7, in_rd, in_operand1, in_operand2, in_s_data};
  // in_ready_q is low exactly when the skid holds an entry, so nothing is
  // ever accepted in FULL.
  assign accept = in_valid & in_ready_q;

  // Next occupancy and register contents; flush wins over any handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = OCC_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            main_d  = in_pl;
            state_d = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (out_ready) begin
            if (accept) begin
              main_d = in_pl;
            end else begin
              main_d  = '0;
              state_d = OCC_EMPTY;
            end
          end else if (accept) begin
            skid_d  = in_pl;
            state_d = OCC_FULL;
          end
        end
        OCC_FULL: begin
          if (out_ready) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = OCC_ONE;
          end
        end
        default: begin
          state_d = OCC_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // State, payload and the registered ready flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= OCC_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != OCC_FULL);
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q != OCC_EMPTY);
  assign out_op       = main_q.op;
  assign out_funct3   = main_q.funct3;
  assign out_funct7   = main_q.funct7;
  assign out_rd       = main_q.rd;
  assign out_operand1 = main_q.operand1;
  assign out_operand2 = main_q.operand2;
  assign out_s_data   = main_q.s_data;

`ifdef ID_EX_PERF_EN
  // Saturating counters: stalls while execute refuses, bubbles while empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (!out_valid && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_skid.sv
// Self-checking bench for id_ex_skid. The reference model is a bounded
// FIFO of depth two: head is what execute sees, ready means fewer than two
// held. Define ID_EX_PERF_EN to also exercise the counters.
`timescale 1ns/1ps
module tb_id_ex_skid;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [31:0] sd;
  } pl_t;

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  pl_t         in_pl, out_pl;
  logic [6:0]  out_op, out_funct7;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rd;
  logic [31:0] out_operand1, out_operand2, out_s_data;

  assign out_pl = {out_op, out_funct3, out_funct7, out_rd, out_operand1, out_operand2, out_s_data};

`ifdef ID_EX_PERF_EN
  logic [15:0] stall_cnt, bubble_cnt;
  logic [1:0]  stall_cnt2, bubble_cnt2;
  logic        in_ready2, out_valid2;
  logic [6:0]  out_op2, out_funct72;
  logic [2:0]  out_funct32;
  logic [4:0]  out_rd2;
  logic [31:0] out_operand12, out_operand22, out_s_data2;
`endif

  id_ex_skid #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_pl.op), .in_funct3(in_pl.f3), .in_funct7(in_pl.f7), .in_rd(in_pl.rd),
    .in_operand1(in_pl.o1), .in_operand2(in_pl.o2), .in_s_data(in_pl.sd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rd(out_rd),
    .out_operand1(out_operand1), .out_operand2(out_operand2), .out_s_data(out_s_data)
`ifdef ID_EX_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

`ifdef ID_EX_PERF_EN
  // Narrow-counter copy sharing the same stimulus, for saturation.
  id_ex_skid #(.DATA_W(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_pl.op), .in_funct3(in_pl.f3), .in_funct7(in_pl.f7), .in_rd(in_pl.rd),
    .in_operand1(in_pl.o1), .in_operand2(in_pl.o2), .in_s_data(in_pl.sd),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_op(out_op2), .out_funct3(out_funct32), .out_funct7(out_funct72), .out_rd(out_rd2),
    .out_operand1(out_operand12), .out_operand2(out_operand22), .out_s_data(out_s_data2),
    .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  pl_t q[$];
  int  m_stall = 0;
  int  m_bubble = 0;

  function automatic pl_t exp_pl();
    if (q.size() > 0) return q[0];
    return '0;
  endfunction

  function automatic pl_t rand_pl();
    pl_t p;
    p.op = 7'($urandom); p.f3 = 3'($urandom); p.f7 = 7'($urandom);
    p.rd = 5'($urandom); p.o1 = $urandom; p.o2 = $urandom; p.sd = $urandom;
    return p;
  endfunction

  // One clock edge: model consumes the same inputs the DUT sees, then we
  // step 1ns past the edge so outputs are settled for checking.
  task automatic tick();
    bit mv, mrdy;
    mv   = (q.size() > 0);
    mrdy = (q.size() < 2);
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (mv && !out_ready && m_stall < 65535) m_stall++;
      if (!mv && m_bubble < 65535) m_bubble++;
      if (flush) q.delete();
      else begin
        if (mv && out_ready) void'(q.pop_front());
        if (in_valid && mrdy) q.push_back(in_pl);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_pl = rand_pl();
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_pl !== '0) begin errors++; $display("FAIL reset_payload: got %h want 0", out_pl); end
`ifdef ID_EX_PERF_EN
    checks++; if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, bubble_cnt); end
`endif
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_pl = rand_pl();
      in_pl.op = 7'b0010011;
      in_pl.o2 = 32'(5 + i);
      tick();
      checks++; if (out_valid !== 1'b1 || out_operand2 !== 32'(5 + i) || out_op !== 7'b0010011) begin
        errors++; $display("FAIL stream_%0d: got v=%b op=%b o2=%0d want v=1 op=0010011 o2=%0d",
                           i, out_valid, out_op, out_operand2, 5 + i); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d: got %b want 1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || out_pl !== '0) begin
      errors++; $display("FAIL stream_drain: got v=%b pl=%h want v=0 pl=0", out_valid, out_pl); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pl = rand_pl(); in_pl.o1 = 32'h11;
    tick();
    checks++; if (out_valid !== 1'b1 || out_operand1 !== 32'h11 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_one: got v=%b o1=%h rdy=%b want v=1 o1=11 rdy=1", out_valid, out_operand1, in_ready); end
    in_pl = rand_pl(); in_pl.o1 = 32'h22;
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_operand1 !== 32'h11) begin
      errors++; $display("FAIL bp_full: got rdy=%b o1=%h want rdy=0 o1=11", in_ready, out_operand1); end
    tick();
    checks++; if (out_operand1 !== 32'h11 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_hold: got v=%b o1=%h want v=1 o1=11", out_valid, out_operand1); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_operand1 !== 32'h22 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got v=%b o1=%h rdy=%b want v=1 o1=22 rdy=1", out_valid, out_operand1, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got v=%b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_pl = rand_pl(); tick();
    in_pl = rand_pl(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefill: got rdy=%b want 0", in_ready); end
    flush = 1'b1; in_pl = rand_pl(); in_pl.o1 = 32'h33;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_pl !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_full: got v=%b pl=%h rdy=%b want v=0 pl=0 rdy=1", out_valid, out_pl, in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost_%0d: got v=%b o1=%h want v=0", i, out_valid, out_operand1); end
    end
  endtask

  task automatic test_store();
    out_ready = 1'b1; in_valid = 1'b1;
    in_pl = rand_pl(); in_pl.op = 7'b0100011; in_pl.o2 = 32'hFFFF_FFFC; in_pl.sd = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_op !== 7'b0100011 || out_operand2 !== 32'hFFFF_FFFC || out_s_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL store: got v=%b op=%b o2=%h sd=%h want v=1 op=0100011 o2=fffffffc sd=deadbeef",
                         out_valid, out_op, out_operand2, out_s_data); end
    tick();
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0; in_valid = 1'b1;
    in_pl = rand_pl(); tick();
    in_pl = rand_pl(); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pl !== '0) begin
      errors++; $display("FAIL reset_full: got v=%b rdy=%b pl=%h want v=0 rdy=1 pl=0", out_valid, in_ready, out_pl); end
    out_ready = 1'b1; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_full_lost: got v=%b want 0", out_valid); end
  endtask

`ifdef ID_EX_PERF_EN
  task automatic test_perf();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0; in_pl = rand_pl();
    tick();                        // one bubble, accept
    in_valid = 1'b0;
    repeat (3) tick();             // three stalls
    out_ready = 1'b1; tick();      // delivery
    repeat (3) tick();             // three more bubbles
    checks++; if (stall_cnt !== 16'd3 || bubble_cnt !== 16'd4) begin
      errors++; $display("FAIL perf_counts: got %0d/%0d want 3/4", stall_cnt, bubble_cnt); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0; tick(); in_valid = 1'b0;
    repeat (5) tick();
    checks++; if (stall_cnt2 !== 2'd3 || stall_cnt !== 16'd5) begin
      errors++; $display("FAIL perf_saturate: got %0d/%0d want 3/5", stall_cnt2, stall_cnt); end
    out_ready = 1'b1; tick();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      in_pl     = rand_pl();
      tick();
      checks++; if (out_valid !== (q.size() > 0)) begin
        errors++; $display("FAIL rand_valid@%0d: got %b want %b", c, out_valid, q.size() > 0); end
      checks++; if (in_ready !== (q.size() < 2)) begin
        errors++; $display("FAIL rand_ready@%0d: got %b want %b", c, in_ready, q.size() < 2); end
      checks++; if (out_pl !== exp_pl()) begin
        errors++; $display("FAIL rand_payload@%0d: got %h want %h", c, out_pl, exp_pl()); end
`ifdef ID_EX_PERF_EN
      checks++; if (stall_cnt !== 16'(m_stall) || bubble_cnt !== 16'(m_bubble)) begin
        errors++; $display("FAIL rand_counters@%0d: got %0d/%0d want %0d/%0d", c, stall_cnt, bubble_cnt, m_stall, m_bubble); end
`endif
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_store();
    test_reset_full();
`ifdef ID_EX_PERF_EN
    test_perf();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
